// File: rtl/collatz_prange.sv
// Evaluates Collatz stopping counts for RAM_WORDS consecutive start values, NUM_LANES at a time,
// storing each count in an internal RAM readable by index with one cycle of registered latency.
module collatz_prange #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int NUM_LANES     = 4,
  parameter int WIDTH         = 32,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [WIDTH-1:0]         start,
  input  logic [RAM_ADDR_BITS-1:0] n,
  output logic [COUNT_BITS-1:0]    count,
  output logic                     done,
  output logic                     busy,
  output logic [COUNT_BITS-1:0]    max_count,
  output logic [RAM_ADDR_BITS-1:0] max_n,
  output logic                     ovf
);

  localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         start_q, start_d;
  logic [RAM_ADDR_BITS-1:0] base_q, base_d;
  logic [LANE_BITS-1:0]     widx_q, widx_d;
  logic                     ovf_q, ovf_d;
  logic [COUNT_BITS-1:0]    max_count_q, max_count_d;
  logic [RAM_ADDR_BITS-1:0] max_n_q, max_n_d;
  logic [COUNT_BITS-1:0]    count_q, count_d;

  logic [WIDTH-1:0]         val_q [NUM_LANES];
  logic [WIDTH-1:0]         val_d [NUM_LANES];
  logic [COUNT_BITS-1:0]    cnt_q [NUM_LANES];
  logic [COUNT_BITS-1:0]    cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0]     fin_q, fin_d;

  logic [COUNT_BITS-1:0]    ram [RAM_WORDS];
  logic                     ram_we;
  logic [RAM_ADDR_BITS-1:0] ram_waddr;
  logic [COUNT_BITS-1:0]    ram_wdata;
  logic                     all_fin;

  function automatic logic [WIDTH+1:0] triple_plus1(input logic [WIDTH-1:0] v);
    return {2'b00, v} + {1'b0, v, 1'b0} + (WIDTH+2)'(1);
  endfunction

  function automatic logic triple_ovf(input logic [WIDTH-1:0] v);
    logic [WIDTH+1:0] t;
    t = triple_plus1(v);
    return |t[WIDTH+1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
    logic [WIDTH+1:0] t;
    t = triple_plus1(v);
    return v[0] ? t[WIDTH-1:0] : (v >> 1);
  endfunction

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    base_d      = base_q;
    widx_d      = widx_q;
    ovf_d       = ovf_q;
    max_count_d = max_count_q;
    max_n_d     = max_n_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    count_d     = ram[n];
    ram_we      = 1'b0;
    ram_waddr   = base_q + RAM_ADDR_BITS'(widx_q);
    ram_wdata   = cnt_q[widx_q];
    all_fin     = 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d     = LOAD;
          start_d     = start;
          base_d      = '0;
          widx_d      = '0;
          ovf_d       = 1'b0;
          max_count_d = '0;
          max_n_d     = '0;
        end
      end
      LOAD: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          val_d[i] = start_q + WIDTH'(base_q) + WIDTH'(i);
          cnt_d[i] = COUNT_BITS'(1);
          fin_d[i] = 1'b0;
        end
        state_d = RUN;
      end
      RUN: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (!fin_q[i]) begin
            if (val_q[i] == WIDTH'(1)) begin
              fin_d[i] = 1'b1;
            end else if (val_q[i] == '0) begin
              fin_d[i] = 1'b1;
              cnt_d[i] = '0;
            end else if ((val_q[i][0] && triple_ovf(val_q[i])) || cnt_q[i] == CNT_MAX) begin
              // Either the value or the count can no longer be represented: saturate.
              fin_d[i] = 1'b1;
              cnt_d[i] = CNT_MAX;
              ovf_d    = 1'b1;
            end else begin
              val_d[i] = step(val_q[i]);
              cnt_d[i] = cnt_q[i] + COUNT_BITS'(1);
            end
          end
          all_fin = all_fin & fin_d[i];
        end
        if (all_fin) state_d = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (ram_wdata > max_count_q) begin
          max_count_d = ram_wdata;
          max_n_d     = ram_waddr;
        end
        if (widx_q == LANE_BITS'(NUM_LANES - 1)) begin
          widx_d  = '0;
          base_d  = base_q + RAM_ADDR_BITS'(NUM_LANES);
          state_d = (base_d == '0) ? DONE : LOAD;
        end else begin
          widx_d = widx_q + LANE_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= '0;
      base_q      <= '0;
      widx_q      <= '0;
      ovf_q       <= 1'b0;
      max_count_q <= '0;
      max_n_q     <= '0;
      count_q     <= '0;
      fin_q       <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        val_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      base_q      <= base_d;
      widx_q      <= widx_d;
      ovf_q       <= ovf_d;
      max_count_q <= max_count_d;
      max_n_q     <= max_n_d;
      count_q     <= count_d;
      fin_q       <= fin_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
    end
  end

  // Result storage is deliberately not cleared by reset; a reset only blocks pending writes.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[ram_waddr] <= ram_wdata;
  end

  assign count     = count_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == WRITE);
  assign max_count = max_count_q;
  assign max_n     = max_n_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/collatz_prange.md
COLLATZ_PRANGE -- requirements
Module: collatz_prange

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, the number of consecutive start values evaluated per run.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 8, with RAM_WORDS = 2**RAM_ADDR_BITS.
REQ-003 SHALL have parameter NUM_LANES, default 4, the number of parallel iteration lanes; it is a power of 2 and divides RAM_WORDS.
REQ-004 SHALL have parameter WIDTH, default 32, the width of the Collatz value datapath.
REQ-005 SHALL have parameter COUNT_BITS, default 16, the width of a stored iteration count.
REQ-006 SHALL have port: clk  in  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port: go  in  1  starts a run when sampled high in IDLE or DONE.
REQ-009 SHALL have port: start  in  WIDTH  the first value of the range, latched on an accepted go.
REQ-010 SHALL have port: n  in  RAM_ADDR_BITS  the result read index, as an offset from start.
REQ-011 SHALL have port: count  out  COUNT_BITS  the stored count for index n.
REQ-012 SHALL have port: done  out  1  high while the state is DONE.
REQ-013 SHALL have port: busy  out  1  high in LOAD, RUN and WRITE.
REQ-014 SHALL have port: max_count  out  COUNT_BITS  the largest count written in the current run.
REQ-015 SHALL have port: max_n  out  RAM_ADDR_BITS  the index of max_count.
REQ-016 SHALL have port: ovf  out  1  sticky flag for a value overflow or count saturation in the current run.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN, WRITE and DONE.
REQ-018 SHALL, on go in IDLE or DONE:
- latch start;
- clear base, ovf, max_count and max_n;
- enter LOAD on the next edge.
REQ-019 SHALL ignore go while busy.
REQ-020 SHALL, in LOAD (1 cycle):
- load lane i with value start+base+i, taken mod 2**WIDTH;
- set each lane's count to 1;
- mark each lane not finished;
- enter RUN.
REQ-021 SHALL, for each unfinished lane in each RUN cycle:
- if the value is 1, mark the lane finished;
- else if the value is 0, mark it finished and set its count to 0;
- else replace the value with v/2 if v is even, or 3v+1 if v is odd, and increment the count.
REQ-022 SHALL finish a lane with count all-ones and set ovf if 3v+1 does not fit in WIDTH bits.
REQ-023 SHALL finish a lane with count all-ones and set ovf if the increment would exceed all-ones.
REQ-024 SHALL leave RUN on the edge after the cycle in which every lane is finished; a batch uses max(lane count) RUN cycles, minimum 1.
REQ-025 SHALL, in WRITE (NUM_LANES cycles), write lane i's count to RAM[base+i], one lane per cycle in ascending i.
REQ-026 SHALL update max_count/max_n during WRITE only on a count strictly greater than max_count, so ties keep the lowest index.
REQ-027 SHALL, after the last WRITE cycle, advance base by NUM_LANES and enter LOAD, or enter DONE if base wraps to 0.
REQ-028 SHALL give count = RAM[n] with 1-cycle registered latency in any state, with a read port independent of the write port.
REQ-029 SHALL, when reading an address in the same cycle it is written, return the old data.
REQ-030 SHALL hold done, max_count, max_n and ovf stable in DONE until the next accepted go.
REQ-031 SHALL drop done on the edge that accepts a go in DONE.

Reset
REQ-032 SHALL, while reset is high, force:
- state to IDLE;
- done, busy, ovf, count, max_count, max_n and base to 0.
REQ-033 SHALL give reset priority over go.
REQ-034 SHALL abort a run in progress when reset is asserted; no further RAM writes occur.
REQ-035 SHALL NOT clear the RAM contents on reset.

Verification
REQ-036 SHALL be covered by: RAM_WORDS=8, NUM_LANES=4, start=1, go pulse at edge 0 -> done=1 in cycle 36; counts 1,2,8,3,6,9,17,4; max_count=17; max_n=6; ovf=0.
REQ-037 SHALL be covered by: after the REQ-036 run, n=2 -> count=8 on the next cycle; n=6 -> 17.
REQ-038 SHALL be covered by: WIDTH=8, start=127 -> count[0]=all-ones; ovf=1; the other lanes are unaffected.
REQ-039 SHALL be covered by: start=0 -> count[0]=0; count[1]=1; no hang.
REQ-040 SHALL be covered by: go repeated mid-RUN -> ignored, with an identical result; reset in RUN -> IDLE next cycle, busy=0, done=0; a new go then completes normally.
REQ-041 SHALL be covered by: go asserted in DONE with a new start -> done=0 next cycle; ovf and max cleared; the new results are stored.
